uart_rx_ctrl: RTL and testbench

Memory-mapped receive controller for the UART receiver. It programs the receiver's 13-bit baud divisor and drains each received byte into an internal FIFO, acknowledging the receiver with a one-cycle `clr_rdy` pulse. It tracks overrun and presents DATA/STATUS/BAUD/CTRL registers plus an interrupt to the processor's MMIO bus. It sits between the processor's MMIO bus and a single UART receiver instance; it does not instantiate the receiver.

---
 rtl/uart_rx_ctrl_pkg.sv | 42 ++++
 rtl/uart_rx_ctrl_if.sv | 31 +++
 rtl/uart_rx_ctrl_rx_fifo.sv | 60 ++++++
 rtl/uart_rx_ctrl.sv | 154 +++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_ctrl_pkg.sv
// rtl/uart_rx_ctrl_pkg.sv - shared register map, bit positions and capture FSM states
package uart_ctrl_pkg;

  // Register addresses on the MMIO bus
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_BAUD   = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  // STATUS bit positions (count occupies [4:0])
  localparam int STAT_OVERRUN = 7;
  localparam int STAT_FULL    = 6;
  localparam int STAT_EMPTY   = 5;

  // CTRL bit positions
  localparam int CTRL_RX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_FLUSH  = 2;

  localparam int BAUD_W = 13;

  // Receiver capture handshake states
  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_ACK  = 1'b1
  } cap_state_e;

  // Pack the STATUS register image
  function automatic logic [15:0] status_word(input logic overrun,
                                              input logic full,
                                              input logic empty,
                                              input logic [4:0] count);
    logic [15:0] w;
    w = 16'h0000;
    w[STAT_OVERRUN] = overrun;
    w[STAT_FULL]    = full;
    w[STAT_EMPTY]   = empty;
    w[4:0]          = count;
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - processor MMIO bus bundle for the receive controller
interface uart_rx_ctrl_if;

  logic [1:0]  bus_addr;
  logic        bus_we;
  logic        bus_re;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;
  logic        irq;

  // Processor side drives accesses and observes data/interrupt
  modport master (
    output bus_addr,
    output bus_we,
    output bus_re,
    output bus_wdata,
    input  bus_rdata,
    input  irq
  );

  // Controller side answers accesses
  modport slave (
    input  bus_addr,
    input  bus_we,
    input  bus_re,
    input  bus_wdata,
    output bus_rdata,
    output irq
  );

endinterface

// File: rtl/uart_rx_ctrl_rx_fifo.sv
// rtl/uart_rx_ctrl_rx_fifo.sv - synchronous byte FIFO with flush and explicit count
module rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  input  logic       flush,
  output logic       full,
  output logic       empty,
  output logic [4:0] count,
  output logic [7:0] head
);

  localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_CNT = 5'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    cnt;
  logic          do_push;
  logic          do_pop;

  assign full  = (cnt == DEPTH_CNT);
  assign empty = (cnt == 5'd0);
  assign count = cnt;
  assign head  = mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage write; a flush in the same cycle discards the incoming byte
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= 5'd0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      cnt <= cnt + {4'b0000, do_push} - {4'b0000, do_pop};
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller: byte capture, RX FIFO, registers, irq
module uart_rx_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [12:0] BAUD_DEFAULT = 13'd434
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                uart_rdy,
  input  logic [7:0]          uart_data,
  output logic                uart_clr_rdy,
  output logic [BAUD_W-1:0]   uart_baud,
  uart_rx_ctrl_if.slave       bus
);

  cap_state_e        state_q;
  cap_state_e        state_d;
  logic              capture;

  logic              rx_en_q;
  logic              irq_en_q;
  logic              overrun_q;
  logic [BAUD_W-1:0] baud_q;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_flush;
  logic              fifo_full;
  logic              fifo_empty;
  logic [4:0]        fifo_count;
  logic [7:0]        fifo_head;

  logic              wr_status;
  logic              wr_baud;
  logic              wr_ctrl;
  logic              overrun_set;
  logic [15:0]       rd_mux;
  logic              unused_wdata;

  // Upper write-data bits carry no register state
  assign unused_wdata = &{1'b0, bus.bus_wdata[15:13]};

  // Capture FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CAP_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture FSM: take one byte per uart_rdy assertion, then wait for the flag to drop
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      CAP_IDLE: begin
        if (uart_rdy && !rst) begin
          capture = 1'b1;
          state_d = CAP_ACK;
        end
      end
      CAP_ACK: begin
        if (!uart_rdy) begin
          state_d = CAP_IDLE;
        end
      end
      default: state_d = CAP_IDLE;
    endcase
  end

  assign uart_clr_rdy = capture;
  assign uart_baud    = baud_q;

  assign wr_status  = bus.bus_we && (bus.bus_addr == ADDR_STATUS);
  assign wr_baud    = bus.bus_we && (bus.bus_addr == ADDR_BAUD);
  assign wr_ctrl    = bus.bus_we && (bus.bus_addr == ADDR_CTRL);

  assign fifo_pop    = bus.bus_re && (bus.bus_addr == ADDR_DATA);
  assign fifo_flush  = wr_ctrl && bus.bus_wdata[CTRL_FLUSH];
  assign fifo_push   = capture && rx_en_q;
  // A byte is lost only when the FIFO is full and no pop makes room this cycle
  assign overrun_set = fifo_push && fifo_full && !(fifo_pop && !fifo_empty);

  rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (uart_data),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  // Configuration and sticky status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_en_q   <= 1'b1;
      irq_en_q  <= 1'b0;
      baud_q    <= BAUD_DEFAULT;
      overrun_q <= 1'b0;
    end else begin
      if (wr_baud) begin
        baud_q <= bus.bus_wdata[BAUD_W-1:0];
      end
      if (wr_ctrl) begin
        rx_en_q  <= bus.bus_wdata[CTRL_RX_EN];
        irq_en_q <= bus.bus_wdata[CTRL_IRQ_EN];
      end
      if (overrun_set) begin
        overrun_q <= 1'b1;
      end else if (wr_status && bus.bus_wdata[STAT_OVERRUN]) begin
        overrun_q <= 1'b0;
      end
    end
  end

  // Read mux from pre-update state; an empty DATA read returns zero
  always_comb begin
    rd_mux = 16'h0000;
    case (bus.bus_addr)
      ADDR_DATA:   rd_mux = fifo_empty ? 16'h0000 : {8'h00, fifo_head};
      ADDR_STATUS: rd_mux = status_word(overrun_q, fifo_full, fifo_empty, fifo_count);
      ADDR_BAUD:   rd_mux = {3'b000, baud_q};
      ADDR_CTRL:   rd_mux = {14'h0000, irq_en_q, rx_en_q};
      default:     rd_mux = 16'h0000;
    endcase
  end

  // Registered read data, held until the next read strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.bus_rdata <= 16'h0000;
    end else if (bus.bus_re) begin
      bus.bus_rdata <= rd_mux;
    end
  end

  // Interrupt follows pending data or overrun one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.irq <= 1'b0;
    end else begin
      bus.irq <= irq_en_q & (~fifo_empty | overrun_q);
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

  logic        clk;
  logic        rst;
  logic        uart_rdy;
  logic [7:0]  uart_data;
  logic        uart_clr_rdy;
  logic [12:0] uart_baud;

  int tests;
  int fails;

  uart_rx_ctrl_if bus_if ();

  uart_rx_ctrl #(
    .FIFO_DEPTH   (8),
    .BAUD_DEFAULT (13'd434)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_rdy     (uart_rdy),
    .uart_data    (uart_data),
    .uart_clr_rdy (uart_clr_rdy),
    .uart_baud    (uart_baud),
    .bus          (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [15:0] data);
    bus_if.bus_addr  = addr;
    bus_if.bus_wdata = data;
    bus_if.bus_we    = 1'b1;
    @(negedge clk);
    bus_if.bus_we    = 1'b0;
  endtask

  task automatic read_check(input logic [1:0] addr, input logic [15:0] exp, input string tag);
    bus_if.bus_addr = addr;
    bus_if.bus_re   = 1'b1;
    @(negedge clk);
    bus_if.bus_re   = 1'b0;
    check(tag, bus_if.bus_rdata, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_rdy  = 1'b1;
    uart_data = b;
    #1;
    check($sformatf("clr_rdy_on_%h", b), {15'd0, uart_clr_rdy}, 16'd1);
    @(negedge clk);
    check($sformatf("clr_rdy_off_%h", b), {15'd0, uart_clr_rdy}, 16'd0);
    uart_rdy = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    uart_rdy = 1'b0;
    uart_data = 8'h00;
    bus_if.bus_addr = 2'd0;
    bus_if.bus_we = 1'b0;
    bus_if.bus_re = 1'b0;
    bus_if.bus_wdata = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_clr_rdy", {15'd0, uart_clr_rdy}, 16'd0);
    check("rst_baud", {3'd0, uart_baud}, 16'd434);
    check("rst_rdata", bus_if.bus_rdata, 16'h0000);
    check("rst_irq", {15'd0, bus_if.irq}, 16'd0);
    read_check(2'd2, 16'd434, "rst_baud_reg");
    read_check(2'd1, 16'h0020, "rst_status");
    read_check(2'd3, 16'h0001, "rst_ctrl");
    check("rdata_held", bus_if.bus_rdata, 16'h0001);

    // Single byte
    send_byte(8'hA5);
    read_check(2'd1, 16'h0001, "single_status");
    read_check(2'd0, 16'h00A5, "single_data");
    read_check(2'd1, 16'h0020, "single_empty");

    // Overrun with nine bytes into an eight-entry FIFO
    for (int i = 1; i <= 9; i++) send_byte(8'(i));
    read_check(2'd1, 16'h00C8, "ovr_status_full");
    for (int i = 1; i <= 8; i++) read_check(2'd0, 16'(i), $sformatf("ovr_data_%0d", i));
    read_check(2'd0, 16'h0000, "ovr_empty_read");
    read_check(2'd1, 16'h00A0, "ovr_status_empty");
    bus_write(2'd1, 16'h0080);
    read_check(2'd1, 16'h0020, "ovr_cleared");

    // Simultaneous pop and push while full
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
    read_check(2'd1, 16'h0048, "sim_full");
    uart_rdy = 1'b1;
    uart_data = 8'h18;
    bus_if.bus_addr = 2'd0;
    bus_if.bus_re = 1'b1;
    #1;
    check("sim_clr_rdy", {15'd0, uart_clr_rdy}, 16'd1);
    @(negedge clk);
    bus_if.bus_re = 1'b0;
    uart_rdy = 1'b0;
    check("sim_pop_data", bus_if.bus_rdata, 16'h0010);
    read_check(2'd1, 16'h0048, "sim_count_kept");
    for (int i = 1; i <= 8; i++) read_check(2'd0, 16'h0010 + 16'(i), $sformatf("sim_drain_%0d", i));
    for (int i = 0; i < 20; i++) begin
      send_byte(8'h40 + 8'(i));
      read_check(2'd0, 16'h0040 + 16'(i), $sformatf("wrap_%0d", i));
    end
    read_check(2'd1, 16'h0020, "wrap_empty");

    // BAUD register
    bus_write(2'd2, 16'hF123);
    check("baud_masked", {3'd0, uart_baud}, 16'h1123);
    read_check(2'd2, 16'h1123, "baud_read");
    bus_if.bus_addr = 2'd2;
    bus_if.bus_wdata = 16'h01B2;
    bus_if.bus_we = 1'b1;
    #1;
    check("baud_before_edge", {3'd0, uart_baud}, 16'h1123);
    @(negedge clk);
    bus_if.bus_we = 1'b0;
    check("baud_after_edge", {3'd0, uart_baud}, 16'h01B2);

    // rx_en=0 acknowledges but discards
    bus_write(2'd3, 16'h0000);
    read_check(2'd3, 16'h0000, "ctrl_off");
    send_byte(8'h77);
    read_check(2'd1, 16'h0020, "rx_disabled_empty");

    // irq timing and flush
    bus_write(2'd3, 16'h0003);
    check("irq_idle", {15'd0, bus_if.irq}, 16'd0);
    uart_rdy = 1'b1;
    uart_data = 8'h5A;
    @(negedge clk);
    uart_rdy = 1'b0;
    check("irq_not_yet", {15'd0, bus_if.irq}, 16'd0);
    @(negedge clk);
    check("irq_rise", {15'd0, bus_if.irq}, 16'd1);
    bus_write(2'd3, 16'h0007);
    read_check(2'd1, 16'h0020, "flush_empty");
    check("flush_irq_low", {15'd0, bus_if.irq}, 16'd0);
    read_check(2'd3, 16'h0003, "ctrl_flush_reads0");

    // Reset mid-operation with uart_rdy still high
    bus_write(2'd2, 16'h0100);
    send_byte(8'hC1);
    send_byte(8'hC2);
    send_byte(8'hC3);
    read_check(2'd1, 16'h0003, "pre_rst_count");
    check("pre_rst_irq", {15'd0, bus_if.irq}, 16'd1);
    rst = 1'b1;
    uart_rdy = 1'b1;
    uart_data = 8'h3C;
    #1;
    check("rst_gates_clr", {15'd0, uart_clr_rdy}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_capture", {15'd0, uart_clr_rdy}, 16'd1);
    check("post_rst_baud", {3'd0, uart_baud}, 16'd434);
    check("post_rst_irq", {15'd0, bus_if.irq}, 16'd0);
    check("post_rst_rdata", bus_if.bus_rdata, 16'h0000);
    @(negedge clk);
    uart_rdy = 1'b0;
    read_check(2'd1, 16'h0001, "post_rst_count");
    read_check(2'd0, 16'h003C, "post_rst_data");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
